// File: rtl/riscv_pcp_sv.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : riscv_pcp_sv                                           |
// | Description : RV32M coprocessor on a PCP-style handshake port.       |
// |               Iterative shift-add multiply / restoring divide with   |
// |               a fixed 33-cycle latency for every operation.          |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module riscv_pcp_sv (
  input  logic        clk,
  input  logic        resetn,
  input  logic        valid,
  input  logic [31:0] instruction,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  output logic        busy,
  output logic        ready,
  output logic [31:0] rd
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] CALC    = 2'd1;
  localparam logic [1:0] DONE    = 2'd2;
  localparam logic [1:0] RELEASE = 2'd3;

  localparam logic [6:0] OPCODE_OP  = 7'b0110011;
  localparam logic [6:0] FUNCT7_MUL = 7'b0000001;
  localparam logic [5:0] ITERATIONS = 6'd32;

  logic [1:0]  state;
  logic [5:0]  count;
  logic [2:0]  func3;      // captured operation
  logic [31:0] opnd;       // multiplicand magnitude or divisor magnitude
  logic [63:0] acc;        // multiply: {partial, multiplier}; divide: {remainder, quotient}
  logic        neg_lo;     // negate product / quotient
  logic        neg_hi;     // negate remainder (divide only)
  logic        special;    // divide-by-zero or signed overflow seen at capture
  logic [31:0] special_val;

  // Decode and operand conditioning of the offered instruction
  logic        is_m;
  logic [2:0]  in_f3;
  logic        in_div;
  logic        a_signed;
  logic        b_signed;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic        div_zero;
  logic        div_ovf;

  assign is_m     = (instruction[6:0] == OPCODE_OP) && (instruction[31:25] == FUNCT7_MUL);
  assign in_f3    = instruction[14:12];
  assign in_div   = in_f3[2];
  // DIV/REM have func3[0]=0; MUL/MULH/MULHSU sign rs1, only MUL/MULH sign rs2.
  assign a_signed = in_div ? ~in_f3[0] : (in_f3[1:0] != 2'b11);
  assign b_signed = in_div ? ~in_f3[0] : ~in_f3[1];
  assign a_neg    = a_signed & rs1[31];
  assign b_neg    = b_signed & rs2[31];
  assign mag_a    = a_neg ? (~rs1 + 32'd1) : rs1;
  assign mag_b    = b_neg ? (~rs2 + 32'd1) : rs2;
  assign div_zero = in_div && (rs2 == 32'd0);
  assign div_ovf  = in_div && a_signed && (rs1 == 32'h8000_0000) && (rs2 == 32'hFFFF_FFFF);

  // One iteration of each algorithm
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [32:0] div_trial;
  logic [63:0] div_next;

  assign mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
  assign mul_next  = {mul_sum, acc[31:1]};
  // Remainder is always below the divisor, so a set bit 32 means the trial borrowed.
  assign div_trial = {acc[63:32], acc[31]} - {1'b0, opnd};
  assign div_next  = div_trial[32] ? {acc[62:0], 1'b0}
                                   : {div_trial[31:0], acc[30:0], 1'b1};

  // Final sign correction and result selection
  logic [63:0] prod_signed;
  logic [31:0] quot_signed;
  logic [31:0] rem_signed;
  logic [31:0] result;

  assign prod_signed = neg_lo ? (~acc + 64'd1) : acc;
  assign quot_signed = neg_lo ? (~acc[31:0] + 32'd1) : acc[31:0];
  assign rem_signed  = neg_hi ? (~acc[63:32] + 32'd1) : acc[63:32];

  // Select the architectural result for the captured func3
  always_comb begin
    result = prod_signed[63:32];
    if (special) begin
      result = special_val;
    end else if (func3[2]) begin
      result = func3[1] ? rem_signed : quot_signed;
    end else if (func3 == 3'b000) begin
      result = prod_signed[31:0];
    end
  end

  // Control FSM and registered outputs
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
      busy  <= 1'b0;
      ready <= 1'b0;
      rd    <= 32'd0;
      count <= 6'd0;
    end else begin
      ready <= 1'b0;
      case (state)
        IDLE: begin
          if (valid && is_m) begin
            state <= CALC;
            busy  <= 1'b1;
            count <= ITERATIONS;
          end
        end
        CALC: begin
          count <= count - 6'd1;
          if (count == 6'd1) begin
            state <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          ready <= 1'b1;
          rd    <= result;
          state <= RELEASE;
        end
        default: begin
          // Wait for the host to retire valid so the same instruction is not re-run.
          if (!valid) begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

  // Datapath: operand capture in IDLE, one iteration per CALC cycle
  always_ff @(posedge clk) begin
    if (state == IDLE && valid && is_m) begin
      func3       <= in_f3;
      opnd        <= in_div ? mag_b : mag_a;
      acc         <= {32'd0, in_div ? mag_a : mag_b};
      neg_lo      <= a_neg ^ b_neg;
      neg_hi      <= in_div ? a_neg : (a_neg ^ b_neg);
      special     <= div_zero | div_ovf;
      special_val <= div_zero ? (in_f3[1] ? rs1 : 32'hFFFF_FFFF)
                              : (in_f3[1] ? 32'd0 : 32'h8000_0000);
    end else if (state == CALC) begin
      acc <= func3[2] ? div_next : mul_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_riscv_pcp_sv.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_riscv_pcp_sv                                        |
// | Description : Directed self-checking bench for riscv_pcp_sv.         |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_riscv_pcp_sv;

  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_MULHU  = 3'b011;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_DIVU   = 3'b101;
  localparam logic [2:0] F_REM    = 3'b110;
  localparam logic [2:0] F_REMU   = 3'b111;

  logic        clk;
  logic        resetn;
  logic        valid;
  logic [31:0] instruction;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        busy;
  logic        ready;
  logic [31:0] rd;

  int errors;
  int checks;

  riscv_pcp_sv dut (
    .clk         (clk),
    .resetn      (resetn),
    .valid       (valid),
    .instruction (instruction),
    .rs1         (rs1),
    .rs2         (rs2),
    .busy        (busy),
    .ready       (ready),
    .rd          (rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] m_instr(input logic [2:0] f3);
    return {7'b0000001, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
  endfunction

  // Arithmetic reference built on wide native multiply/divide
  function automatic logic [31:0] ref_m(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic [63:0]        p;
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic signed [31:0] sq;
    sa = a;
    sb = b;
    case (f3)
      F_MUL:    begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
      F_MULH:   begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[63:32]; end
      F_MULHSU: begin p = {{32{a[31]}}, a} * {32'd0, b}; return p[63:32]; end
      F_MULHU:  begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      F_DIV: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        sq = sa / sb;
        return sq;
      end
      F_REM: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        sq = sa % sb;
        return sq;
      end
      F_DIVU:  return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  // Drive one instruction and wait (bounded) for the ready pulse.
  task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int lat,
                       output logic acc_busy, output logic overlap);
    @(posedge clk); #1;
    valid       = 1'b1;
    instruction = m_instr(f3);
    rs1         = a;
    rs2         = b;
    @(posedge clk); #1;
    acc_busy = busy;
    overlap  = 1'b0;
    lat      = -1;
    res      = 'x;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk); #1;
      if (busy && ready) overlap = 1'b1;
      if (ready) begin
        lat = i;
        res = rd;
        break;
      end
    end
    valid       = 1'b0;
    instruction = 32'd0;
    rs1         = 32'd0;
    rs2         = 32'd0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", ready); end
    checks++; if (rd !== 32'd0)   begin errors++; $display("FAIL reset_rd got=%h exp=00000000", rd); end
    resetn = 1'b1;
  endtask

  task automatic test_mul();
    logic [31:0] res;
    int          lat;
    logic        ab;
    logic        ov;
    do_op(F_MUL, 32'h0000_0015, 32'h0000_0788, res, lat, ab, ov);
    checks++; if (res !== 32'h0000_9E28) begin errors++; $display("FAIL mul_result got=%h exp=00009e28", res); end
    checks++; if (lat !== 33)    begin errors++; $display("FAIL mul_latency got=%0d exp=33", lat); end
    checks++; if (ab !== 1'b1)   begin errors++; $display("FAIL mul_busy_on_accept got=%b exp=1", ab); end
    checks++; if (ov !== 1'b0)   begin errors++; $display("FAIL mul_busy_ready_overlap got=%b exp=0", ov); end
    repeat (5) @(posedge clk);
    #1;
    checks++; if (rd !== 32'h0000_9E28) begin errors++; $display("FAIL mul_rd_hold got=%h exp=00009e28", rd); end
    checks++; if (ready !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mul_idle_outputs got=%b%b exp=00", busy, ready); end
  endtask

  task automatic test_mulh();
    logic [31:0] res;
    int          lat;
    logic        ab;
    logic        ov;
    do_op(F_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, lat, ab, ov);
    checks++; if (res !== 32'h0000_0000) begin errors++; $display("FAIL mulh got=%h exp=00000000", res); end
    do_op(F_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, lat, ab, ov);
    checks++; if (res !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mulhsu got=%h exp=ffffffff", res); end
    do_op(F_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, lat, ab, ov);
    checks++; if (res !== 32'hFFFF_FFFE) begin errors++; $display("FAIL mulhu got=%h exp=fffffffe", res); end
  endtask

  task automatic test_div_zero();
    logic [31:0] res;
    int          lat;
    logic        ab;
    logic        ov;
    do_op(F_DIV, 32'h9502_F900, 32'd0, res, lat, ab, ov);
    checks++; if (res !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div0_div got=%h exp=ffffffff", res); end
    checks++; if (lat !== 33) begin errors++; $display("FAIL div0_latency got=%0d exp=33", lat); end
    do_op(F_DIVU, 32'h9502_F900, 32'd0, res, lat, ab, ov);
    checks++; if (res !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div0_divu got=%h exp=ffffffff", res); end
    do_op(F_REM, 32'h0000_0015, 32'd0, res, lat, ab, ov);
    checks++; if (res !== 32'h0000_0015) begin errors++; $display("FAIL div0_rem got=%h exp=00000015", res); end
    do_op(F_REMU, 32'h0000_0015, 32'd0, res, lat, ab, ov);
    checks++; if (res !== 32'h0000_0015) begin errors++; $display("FAIL div0_remu got=%h exp=00000015", res); end
  endtask

  task automatic test_overflow();
    logic [31:0] res;
    int          lat;
    logic        ab;
    logic        ov;
    do_op(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, res, lat, ab, ov);
    checks++; if (res !== 32'h8000_0000) begin errors++; $display("FAIL ovf_div got=%h exp=80000000", res); end
    checks++; if (lat !== 33) begin errors++; $display("FAIL ovf_latency got=%0d exp=33", lat); end
    do_op(F_REM, 32'h8000_0000, 32'hFFFF_FFFF, res, lat, ab, ov);
    checks++; if (res !== 32'h0000_0000) begin errors++; $display("FAIL ovf_rem got=%h exp=00000000", res); end
    do_op(F_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, res, lat, ab, ov);
    checks++; if (res !== 32'h0000_0000) begin errors++; $display("FAIL ovf_divu got=%h exp=00000000", res); end
    do_op(F_REMU, 32'h8000_0000, 32'hFFFF_FFFF, res, lat, ab, ov);
    checks++; if (res !== 32'h8000_0000) begin errors++; $display("FAIL ovf_remu got=%h exp=80000000", res); end
  endtask

  task automatic test_rounding();
    logic [31:0] res;
    int          lat;
    logic        ab;
    logic        ov;
    do_op(F_DIV, 32'hFFFF_FFF9, 32'd2, res, lat, ab, ov);
    checks++; if (res !== 32'hFFFF_FFFD) begin errors++; $display("FAIL round_div got=%h exp=fffffffd", res); end
    do_op(F_REM, 32'hFFFF_FFF9, 32'd2, res, lat, ab, ov);
    checks++; if (res !== 32'hFFFF_FFFF) begin errors++; $display("FAIL round_rem got=%h exp=ffffffff", res); end
    do_op(F_DIVU, 32'hFFFF_FFF9, 32'd2, res, lat, ab, ov);
    checks++; if (res !== 32'h7FFF_FFFC) begin errors++; $display("FAIL round_divu got=%h exp=7ffffffc", res); end
    do_op(F_REMU, 32'hFFFF_FFF9, 32'd2, res, lat, ab, ov);
    checks++; if (res !== 32'h0000_0001) begin errors++; $display("FAIL round_remu got=%h exp=00000001", res); end
  endtask

  task automatic test_random();
    logic [31:0] res;
    logic [31:0] exp_v;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  f3;
    int          lat;
    logic        ab;
    logic        ov;
    for (int i = 0; i < 24; i++) begin
      f3 = i[2:0];
      a  = $urandom;
      b  = $urandom;
      if (f3[2]) b = b >> $urandom_range(0, 28);
      exp_v = ref_m(f3, a, b);
      do_op(f3, a, b, res, lat, ab, ov);
      checks++;
      if (res !== exp_v || lat !== 33) begin
        errors++;
        $display("FAIL random_op f3=%b a=%h b=%h got=%h lat=%0d exp=%h lat=33", f3, a, b, res, lat, exp_v);
      end
    end
  endtask

  task automatic test_back_to_back_hold();
    int   nready;
    logic rebusy;
    nready = 0;
    rebusy = 1'b0;
    @(posedge clk); #1;
    valid       = 1'b1;
    instruction = m_instr(F_MUL);
    rs1         = 32'd6;
    rs2         = 32'd7;
    for (int i = 0; i < 60 && nready == 0; i++) begin
      @(posedge clk); #1;
      if (ready) nready++;
    end
    repeat (2) begin
      @(posedge clk); #1;
      if (ready) nready++;
      if (busy) rebusy = 1'b1;
    end
    valid = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (ready) nready++;
      if (busy) rebusy = 1'b1;
    end
    checks++; if (nready !== 1)     begin errors++; $display("FAIL hold_ready_count got=%0d exp=1", nready); end
    checks++; if (rebusy !== 1'b0)  begin errors++; $display("FAIL hold_rerun_busy got=%b exp=0", rebusy); end
    checks++; if (rd !== 32'h0000_002A) begin errors++; $display("FAIL hold_result got=%h exp=0000002a", rd); end
  endtask

  task automatic test_non_m();
    logic saw_busy;
    logic saw_ready;
    saw_busy  = 1'b0;
    saw_ready = 1'b0;
    @(posedge clk); #1;
    valid       = 1'b1;
    instruction = {7'b0000000, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011};
    rs1         = 32'd9;
    rs2         = 32'd9;
    repeat (40) begin
      @(posedge clk); #1;
      if (busy) saw_busy = 1'b1;
      if (ready) saw_ready = 1'b1;
    end
    valid = 1'b0;
    checks++; if (saw_busy !== 1'b0)  begin errors++; $display("FAIL nonm_busy got=%b exp=0", saw_busy); end
    checks++; if (saw_ready !== 1'b0) begin errors++; $display("FAIL nonm_ready got=%b exp=0", saw_ready); end
  endtask

  task automatic test_reset_mid_calc();
    int nready;
    nready = 0;
    @(posedge clk); #1;
    valid       = 1'b1;
    instruction = m_instr(F_MUL);
    rs1         = 32'd3;
    rs2         = 32'd5;
    repeat (10) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before got=%b exp=1", busy); end
    resetn = 1'b0;
    valid  = 1'b0;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL midrst_ready got=%b exp=0", ready); end
    checks++; if (rd !== 32'd0)   begin errors++; $display("FAIL midrst_rd got=%h exp=00000000", rd); end
    resetn = 1'b1;
    repeat (40) begin
      @(posedge clk); #1;
      if (ready) nready++;
    end
    checks++; if (nready !== 0) begin errors++; $display("FAIL midrst_late_ready got=%0d exp=0", nready); end
  endtask

  initial begin
    errors      = 0;
    checks      = 0;
    resetn      = 1'b0;
    valid       = 1'b0;
    instruction = 32'd0;
    rs1         = 32'd0;
    rs2         = 32'd0;
    test_reset();
    test_mul();
    test_mulh();
    test_div_zero();
    test_overflow();
    test_rounding();
    test_random();
    test_back_to_back_hold();
    test_non_m();
    test_reset_mid_calc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
